uart_tx: RTL and testbench

Serial UART transmitter: accepts one byte over a valid/ready handshake and shifts it out on `tx` as a standard asynchronous frame (start bit, 8 data bits LSB first, optional parity, one stop bit). It is the transmit half of the `rxtx` pair. It sits between the echo-buffer read path (`tx_vld`/`tx_data` from the RAM stage) and the `UART_TXD` pin. Its `txrdy` rising edge paces the buffer's read-address advance.

---
 rtl/uart_tx.sv | 129 ++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready intake, serialised as start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even parity bit between data bit 7 and stop.
module uart_tx #(
    parameter int unsigned BAUD_DIV = 217,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tx_vld_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_o,
    output logic              txrdy_o
);

    localparam int unsigned     CntW    = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(BAUD_DIV - 1);
    localparam logic [2:0]      BitLast = 3'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                txrdy_q, txrdy_d;
    logic                baud_end;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign baud_end = (cnt_q == CntMax);
    assign tx_o     = tx_q;
    assign txrdy_o  = txrdy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            txrdy_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            txrdy_q <= txrdy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_vld_i) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data_i;
`endif
                end
            end
            StStart: begin
                cnt_d = baud_end ? '0 : cnt_q + CntW'(1);
                if (baud_end) state_d = StData;
            end
            StData: begin
                cnt_d = baud_end ? '0 : cnt_q + CntW'(1);
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == BitLast) state_d = StParity;
`else
                    if (bit_q == BitLast) state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                cnt_d = baud_end ? '0 : cnt_q + CntW'(1);
                if (baud_end) state_d = StStop;
            end
`endif
            StStop: begin
                cnt_d = baud_end ? '0 : cnt_q + CntW'(1);
                if (baud_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the next state so tx/txrdy flops change on the same edge as state.
    always_comb begin
        tx_d    = 1'b1;
        txrdy_d = 1'b0;
        unique case (state_d)
            StIdle:   txrdy_d = 1'b1;
            StStart:  tx_d    = 1'b0;
            StData:   tx_d    = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d    = par_q;
`endif
            StStop:   tx_d    = 1'b1;
            default:  tx_d    = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at BAUD_DIV=4; define UART_TX_PARITY_EN to cover the 8E1 frame.
module tb_uart_tx;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int N = NBITS * B;

    logic       clk;
    logic       rst_n;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       tx;
    logic       txrdy;

    int         checks;
    int         failures;
    logic [7:0] exp_q[$];

    uart_tx #(
        .BAUD_DIV(B),
        .DATA_W  (8)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .tx_vld_i (tx_vld),
        .tx_data_i(tx_data),
        .tx_o     (tx),
        .txrdy_o  (txrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of frame bit k (0 = start) for byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(input logic [127:0] w, input int base);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = w[base + (k + 1) * B + B / 2];
        return d;
    endfunction

    // Starts at a negedge with txrdy=1; sample j is taken at the negedge after edge E0+j.
    task automatic run_frame(input logic [7:0] b, input int poke_j, input logic poke_vld,
                             input logic [7:0] poke_d, input int len,
                             output logic [127:0] txw, output logic [127:0] rdyw);
        txw  = '1;
        rdyw = '0;
        tx_data = b;
        tx_vld  = 1'b1;
        exp_q.push_back(b);
        @(posedge clk);
        @(negedge clk);
        tx_vld = 1'b0;
        for (int j = 0; j < len; j++) begin
            txw[j]  = tx;
            rdyw[j] = txrdy;
            if (j == poke_j) begin
                tx_vld  = poke_vld;
                tx_data = poke_d;
            end else if (j == poke_j + 1) begin
                tx_vld = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        tx_vld  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        checks++;
        if (txrdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_txrdy: got %b want 1", txrdy);
        end
        rst_n = 1'b1;
    endtask

    // Entered at the release negedge, so E0 is the first edge after reset deassertion.
    task automatic test_single;
        logic [127:0] txw, rdyw, ew, er;
        logic [7:0]   got, want;
        run_frame(8'hA5, -1, 1'b0, 8'h00, N + 1, txw, rdyw);
        ew = '1;
        er = '0;
        for (int j = 0; j <= N; j++) begin
            ew[j] = (j < N) ? exp_bit(8'hA5, j / B) : 1'b1;
            er[j] = (j >= N);
        end
        checks++;
        if (txw !== ew) begin
            failures++;
            $display("FAIL single_wave: got %h want %h", txw, ew);
        end
        checks++;
        if (rdyw !== er) begin
            failures++;
            $display("FAIL single_txrdy: got %h want %h", rdyw, er);
        end
        got  = decode(txw, 0);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL single_data: got %h want %h", got, want);
        end
    endtask

    task automatic test_ignore_busy;
        logic [127:0] txw, rdyw, ew;
        logic [7:0]   got, want;
        run_frame(8'h55, 9, 1'b1, 8'hFF, N + 2 * B, txw, rdyw);
        ew = '1;
        for (int j = 0; j < N; j++) ew[j] = exp_bit(8'h55, j / B);
        checks++;
        if (txw !== ew) begin
            failures++;
            $display("FAIL ignore_wave: got %h want %h", txw, ew);
        end
        got  = decode(txw, 0);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL ignore_data: got %h want %h", got, want);
        end
        checks++;
        if (rdyw[N + 2 * B - 1] !== 1'b1) begin
            failures++;
            $display("FAIL ignore_idle: got txrdy %b want 1", rdyw[N + 2 * B - 1]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_scoreboard: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] txw, ew;
        logic [7:0]   got, want;
        int           second, stop_run;
        txw     = '1;
        tx_data = 8'h00;
        tx_vld  = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        for (int j = 0; j < 2 * N + 2; j++) begin
            txw[j] = tx;
            if (j == N + 1) tx_vld = 1'b0;
            @(negedge clk);
        end
        ew = '1;
        for (int j = 0; j < 2 * N + 2; j++) begin
            if (j < N) ew[j] = exp_bit(8'h00, j / B);
            else if (j > N && j < 2 * N + 1) ew[j] = exp_bit(8'hFF, (j - N - 1) / B);
            else ew[j] = 1'b1;
        end
        checks++;
        if (txw !== ew) begin
            failures++;
            $display("FAIL b2b_wave: got %h want %h", txw, ew);
        end
        second = -1;
        for (int j = 1; j < 2 * N + 2; j++)
            if (second < 0 && txw[j - 1] == 1'b1 && txw[j] == 1'b0) second = j;
        checks++;
        if (second != N + 1) begin
            failures++;
            $display("FAIL b2b_period: got %0d want %0d", second, N + 1);
        end
        stop_run = 0;
        for (int j = (second > 0 ? second : 1) - 1; j >= 0 && txw[j] == 1'b1; j--) stop_run++;
        checks++;
        if (stop_run != B + 1) begin
            failures++;
            $display("FAIL b2b_stop_len: got %0d want %0d", stop_run, B + 1);
        end
        got  = decode(txw, 0);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL b2b_data0: got %h want %h", got, want);
        end
        got  = decode(txw, N + 1);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL b2b_data1: got %h want %h", got, want);
        end
    endtask

    task automatic test_capture_isolation;
        logic [127:0] txw, rdyw, ew;
        logic [7:0]   got, want;
        run_frame(8'h3C, 0, 1'b0, 8'hC3, N + 1, txw, rdyw);
        ew = '1;
        for (int j = 0; j < N; j++) ew[j] = exp_bit(8'h3C, j / B);
        checks++;
        if (txw !== ew) begin
            failures++;
            $display("FAIL iso_wave: got %h want %h", txw, ew);
        end
        got  = decode(txw, 0);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL iso_data: got %h want %h", got, want);
        end
    endtask

    task automatic test_reset_mid_frame;
        int lows;
        tx_data = 8'hA5;
        tx_vld  = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        @(negedge clk);
        tx_vld = 1'b0;
        repeat (16) @(negedge clk);
        // Frame bit 4 of 8'hA5 is data bit 3, a zero.
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre_tx: got %b want 0", tx);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL midrst_tx: got %b want 1", tx);
        end
        checks++;
        if (txrdy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_txrdy: got %b want 1", txrdy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        for (int j = 0; j < 3 * N; j++) begin
            @(negedge clk);
            if (tx !== 1'b1 || txrdy !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got %0d busy samples want 0", lows);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [127:0] txw, rdyw, er;
        logic [7:0]   got, want;
        logic [7:0]   bytes[2];
        bytes[0] = 8'h07;
        bytes[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            run_frame(bytes[i], -1, 1'b0, 8'h00, N + 1, txw, rdyw);
            checks++;
            if (txw[9 * B + B / 2] !== ^bytes[i]) begin
                failures++;
                $display("FAIL parity_bit_%0d: got %b want %b", i, txw[9 * B + B / 2], ^bytes[i]);
            end
            er = '0;
            er[N] = 1'b1;
            checks++;
            if (rdyw !== er) begin
                failures++;
                $display("FAIL parity_len_%0d: got %h want %h", i, rdyw, er);
            end
            got  = decode(txw, 0);
            want = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL parity_data_%0d: got %h want %h", i, got, want);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_ignore_busy();
        test_back_to_back();
        test_capture_isolation();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
